// File: rtl/axi_burst_beat_gen.sv
// axi_burst_beat_gen: pops one packed AXI request {id, addr, len, size, burst} from the
// upstream request FIFO and expands it into per-beat addresses (FIXED / INCR / WRAP) on a
// valid/ready beat interface. The next request is popped only after the burst drains.
// Optional build macro AXI_4K_CHECK_EN adds a 4KB-boundary crossing flag for INCR bursts;
// without it beat_err is tied low.
module axi_burst_beat_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned REQ_WIDTH  = ID_WIDTH + ADDR_WIDTH + 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic [REQ_WIDTH-1:0]  fifo_dout,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [2:0]            beat_size,
  output logic [7:0]            beat_idx,
  output logic                  beat_last,
  output logic                  beat_err,
  output logic                  busy
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [1:0] {StIdle, StFetch, StBeat} state_e;
  // Effective address mode after folding reserved bursts and illegal WRAP lengths.
  typedef enum logic [1:0] {ModeFixed, ModeIncr, ModeWrap} mode_e;

  state_e state_q, state_d;

  // Unpacked view of the FIFO word; only meaningful in StFetch.
  logic [1:0]          req_burst;
  logic [2:0]          req_size;
  logic [7:0]          req_len;
  addr_t               req_addr;
  logic [ID_WIDTH-1:0] req_id;
  mode_e               req_mode;
  addr_t               req_bytes;
  addr_t               req_wrap_mask;

  assign req_burst = fifo_dout[1:0];
  assign req_size  = fifo_dout[4:2];
  assign req_len   = fifo_dout[12:5];
  assign req_addr  = fifo_dout[ADDR_WIDTH+12:13];
  assign req_id    = fifo_dout[ADDR_WIDTH+ID_WIDTH+12:ADDR_WIDTH+13];

  assign req_bytes     = addr_t'(1) << req_size;
  // len+1 is a power of two whenever WRAP is honoured, so the shift gives the wrap span.
  assign req_wrap_mask = ((addr_t'(req_len) + addr_t'(1)) << req_size) - addr_t'(1);

  // Decode the effective address mode of the incoming request
  always_comb begin
    case (req_burst)
      2'b01:   req_mode = ModeIncr;
      2'b10:   req_mode = (req_len inside {8'd1, 8'd3, 8'd7, 8'd15}) ? ModeWrap : ModeIncr;
      default: req_mode = ModeFixed;
    endcase
  end

  // Burst context registers
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [2:0]          size_q, size_d;
  logic [7:0]          len_q, len_d;
  mode_e               mode_q, mode_d;
  addr_t               wrap_mask_q, wrap_mask_d;
  addr_t               lower_q, lower_d;
  addr_t               cur_addr_q, cur_addr_d;
  logic [7:0]          idx_q, idx_d;
  addr_t               beat_bytes;
  addr_t               next_addr;

`ifdef AXI_4K_CHECK_EN
  logic  err_q, err_d;
  addr_t req_last_addr;
  logic  req_err;

  assign req_last_addr = (req_addr & ~(req_bytes - addr_t'(1))) + (addr_t'(req_len) << req_size);
  assign req_err = (req_mode == ModeIncr) &&
                   (req_addr[ADDR_WIDTH-1:12] != req_last_addr[ADDR_WIDTH-1:12]);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (fifo_ren) state_d = StFetch;
      StFetch: state_d = StBeat;
      StBeat:  if (beat_ready && (idx_q == len_q)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    fifo_ren   = (state_q == StIdle) && !fifo_empty;
    beat_valid = (state_q == StBeat);
    busy       = (state_q != StIdle);
  end

  // Address of the following beat, derived from the current one
  always_comb begin
    beat_bytes = addr_t'(1) << size_q;
    case (mode_q)
      ModeIncr: next_addr = (cur_addr_q & ~(beat_bytes - addr_t'(1))) + beat_bytes;
      ModeWrap: next_addr = lower_q + ((cur_addr_q + beat_bytes - lower_q) & wrap_mask_q);
      default:  next_addr = cur_addr_q;
    endcase
  end

  // Datapath next-state: load on fetch, advance on each accepted non-final beat
  always_comb begin
    id_d        = id_q;
    size_d      = size_q;
    len_d       = len_q;
    mode_d      = mode_q;
    wrap_mask_d = wrap_mask_q;
    lower_d     = lower_q;
    cur_addr_d  = cur_addr_q;
    idx_d       = idx_q;
`ifdef AXI_4K_CHECK_EN
    err_d       = err_q;
`endif
    if (state_q == StFetch) begin
      id_d        = req_id;
      size_d      = req_size;
      len_d       = req_len;
      mode_d      = req_mode;
      wrap_mask_d = req_wrap_mask;
      lower_d     = req_addr & ~req_wrap_mask;
      cur_addr_d  = req_addr;
      idx_d       = 8'd0;
`ifdef AXI_4K_CHECK_EN
      err_d       = req_err;
`endif
    end else if (beat_valid && beat_ready && (idx_q != len_q)) begin
      cur_addr_d = next_addr;
      idx_d      = idx_q + 8'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q        <= '0;
      size_q      <= '0;
      len_q       <= '0;
      mode_q      <= ModeFixed;
      wrap_mask_q <= '0;
      lower_q     <= '0;
      cur_addr_q  <= '0;
      idx_q       <= '0;
`ifdef AXI_4K_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      id_q        <= id_d;
      size_q      <= size_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      wrap_mask_q <= wrap_mask_d;
      lower_q     <= lower_d;
      cur_addr_q  <= cur_addr_d;
      idx_q       <= idx_d;
`ifdef AXI_4K_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign beat_addr = cur_addr_q;
  assign beat_id   = id_q;
  assign beat_size = size_q;
  assign beat_idx  = idx_q;
  assign beat_last = beat_valid && (idx_q == len_q);

`ifdef AXI_4K_CHECK_EN
  assign beat_err = err_q;
`else
  assign beat_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_beat_gen.sv
// Bench for axi_burst_beat_gen: FIFO model feeding packed requests, beat consumer with
// directed and random backpressure, and an arithmetic reference model for beat addresses.
module tb_axi_burst_beat_gen;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int RW = IW + AW + 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_ren;
  logic [RW-1:0] fifo_dout = '0;
  logic          beat_valid;
  logic          beat_ready = 1'b0;
  logic [AW-1:0] beat_addr;
  logic [IW-1:0] beat_id;
  logic [2:0]    beat_size;
  logic [7:0]    beat_idx;
  logic          beat_last;
  logic          beat_err;
  logic          busy;

  axi_burst_beat_gen #(
    .ADDR_WIDTH (AW),
    .ID_WIDTH   (IW),
    .REQ_WIDTH  (RW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .fifo_dout  (fifo_dout),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_id    (beat_id),
    .beat_size  (beat_size),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .beat_err   (beat_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } req_t;

  logic [RW-1:0] hw_q[$];
  req_t          exp_q[$];

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned ren_cyc = 0;
  int unsigned ren_count = 0;
  int unsigned ren_bad = 0;

  // Request FIFO model: dout valid the cycle after the read strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_ren) begin
      ren_count <= ren_count + 1;
      ren_cyc   <= cyc;
      if (fifo_empty || busy) ren_bad <= ren_bad + 1;
      if (hw_q.size() > 0) fifo_dout <= hw_q.pop_front();
    end
    fifo_empty <= (hw_q.size() == 0);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // 0 fixed, 1 incr, 2 wrap
  function automatic int mode_of(input req_t r);
    case (r.burst)
      2'b01:   return 1;
      2'b10:   return (r.len == 1 || r.len == 3 || r.len == 7 || r.len == 15) ? 2 : 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [AW-1:0] model_addr(input req_t r, input int n);
    logic [63:0] bytes, start, wb, lower, res;
    bytes = 64'd1 << r.size;
    start = {32'd0, r.addr};
    case (mode_of(r))
      1: res = (n == 0) ? start : (start & ~(bytes - 1)) + 64'(n) * bytes;
      2: begin
        wb    = bytes * (64'(r.len) + 1);
        lower = start & ~(wb - 1);
        res   = lower + ((start - lower + 64'(n) * bytes) % wb);
      end
      default: res = start;
    endcase
    return res[AW-1:0];
  endfunction

  function automatic logic model_err(input req_t r);
`ifdef AXI_4K_CHECK_EN
    logic [63:0] bytes, first, last;
    bytes = 64'd1 << r.size;
    first = {32'd0, r.addr};
    last  = ((first & ~(bytes - 1)) + 64'(r.len) * bytes) & 64'hFFFF_FFFF;
    return (mode_of(r) == 1) && (first[31:12] != last[31:12]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    req_t r;
    r.id = id; r.addr = addr; r.len = len; r.size = size; r.burst = burst;
    hw_q.push_back({id, addr, len, size, burst});
    exp_q.push_back(r);
  endtask

  // Drain one burst. rpat==0 gives random ready, else ready cycles through rpat bits.
  // abort_at selects a beat index at which reset is pulsed (-1: none).
  task automatic consume(input bit [3:0] rpat, input int abort_at);
    req_t r;
    int   n, k, waited;
    bit   rdy;
    r = exp_q.pop_front();
    waited = 0;
    while (!beat_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!beat_valid) begin
      check("first_valid_timeout", 64'(beat_valid), 64'd1);
      return;
    end
    check("latency_ren_to_valid", 64'(cyc - ren_cyc), 64'd2);
    n = 0;
    k = 0;
    while (n <= int'(r.len)) begin
      check("beat_valid", 64'(beat_valid), 64'd1);
      check("busy", 64'(busy), 64'd1);
      check("no_ren_in_burst", 64'(fifo_ren), 64'd0);
      check("beat_addr", 64'(beat_addr), 64'(model_addr(r, n)));
      check("beat_id", 64'(beat_id), 64'(r.id));
      check("beat_size", 64'(beat_size), 64'(r.size));
      check("beat_idx", 64'(beat_idx), 64'(n));
      check("beat_last", 64'(beat_last), 64'(n == int'(r.len)));
      check("beat_err", 64'(beat_err), 64'(model_err(r)));
      if (n == abort_at) begin
        beat_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(beat_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_idx", 64'(beat_idx), 64'd0);
        check("rst_addr", 64'(beat_addr), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      rdy = (rpat == 4'd0) ? ($urandom_range(0, 2) != 0) : rpat[k % 4];
      k++;
      beat_ready = rdy;
      @(negedge clk);
      if (rdy) n++;
      if (k > 4000) begin
        check("beat_drain_timeout", 64'(n), 64'(r.len) + 1);
        return;
      end
    end
    beat_ready = 1'b0;
    check("bubble_valid", 64'(beat_valid), 64'd0);
    check("bubble_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int unsigned ren_before;
    logic [7:0]  rlen;

    // Reset state
    #1;
    check("reset_valid", 64'(beat_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ren", 64'(fifo_ren), 64'd0);
    check("reset_addr", 64'(beat_addr), 64'd0);
    check("reset_idx", 64'(beat_idx), 64'd0);
    check("reset_last", 64'(beat_last), 64'd0);
    check("reset_err", 64'(beat_err), 64'd0);
    check("reset_id", 64'(beat_id), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // INCR unaligned start, full throughput
    push(4'h3, 32'h0000_1004, 8'd3, 3'd2, 2'b01);
    consume(4'b1111, -1);

    // WRAP legal length, then WRAP with len=2 behaving as INCR
    push(4'h5, 32'h0000_2038, 8'd3, 3'd3, 2'b10);
    consume(4'b1111, -1);
    push(4'h6, 32'h0000_2038, 8'd2, 3'd3, 2'b10);
    consume(4'b1111, -1);

    // FIXED and reserved burst
    push(4'h7, 32'h0000_0040, 8'd2, 3'd2, 2'b00);
    consume(4'b1111, -1);
    push(4'h8, 32'h0000_0040, 8'd2, 3'd2, 2'b11);
    consume(4'b1111, -1);

    // Single-beat burst
    push(4'h9, 32'h0000_0100, 8'd0, 3'd1, 2'b01);
    consume(4'b1111, -1);

    // Backpressure pattern 1,0,0,1
    push(4'hA, 32'h0000_3000, 8'd3, 3'd2, 2'b01);
    consume(4'b1001, -1);

    // Two requests back-to-back
    ren_before = ren_count;
    push(4'hB, 32'h0000_4000, 8'd1, 3'd2, 2'b01);
    push(4'hC, 32'h0000_5010, 8'd3, 3'd2, 2'b10);
    consume(4'b1111, -1);
    consume(4'b1111, -1);
    @(negedge clk);
    check("b2b_ren_pulses", 64'(ren_count - ren_before), 64'd2);

    // Reset mid-burst, then a fresh request starts at idx 0
    push(4'hD, 32'h0000_6000, 8'd7, 3'd2, 2'b01);
    consume(4'b1111, 2);
    push(4'hE, 32'h0000_7000, 8'd1, 3'd2, 2'b01);
    consume(4'b1111, -1);

    // 4KB crossing INCR (beat_err expected only when the check is built)
    push(4'hF, 32'h0000_0FF8, 8'd1, 3'd3, 2'b01);
    consume(4'b1111, -1);

    // Random requests and backpressure
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0:       rlen = 8'($urandom_range(0, 31));
        1:       rlen = 8'd1;
        2:       rlen = 8'd3;
        3:       rlen = 8'd7;
        default: rlen = 8'd15;
      endcase
      push(IW'($urandom), $urandom, rlen, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      if ((i % 5) == 4) begin
        push(IW'($urandom), $urandom, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)));
        consume(4'd0, -1);
      end
      consume(4'd0, -1);
    end

    check("ren_protocol_violations", 64'(ren_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
